multi_sprite_compositor: RTL and testbench



---
 rtl/multi_sprite_compositor.sv | 183 ++++++++++++++++++
 tb/tb_multi_sprite_compositor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_sprite_compositor.sv
// Composites NUM_SPRITES 1-bpp sprites over a per-pixel background colour, with
// frame-synchronous double-buffered attributes and a per-frame collision report.
module multi_sprite_compositor #(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12,
  parameter int SCALE_LOG2    = 3,
  parameter int COORD_W       = 11,
  parameter int WIDTH_SMALL   = 100,
  parameter int HEIGHT_SMALL  = 75,
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int RW = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [COORD_W-1:0]      counter_h_i,
  input  logic [COORD_W-1:0]      counter_v_i,
  input  logic                    blank_i,
  input  logic                    next_frame_i,
  input  logic [5:0]              bg_color_i,
  input  logic                    attr_we_i,
  input  logic [IW-1:0]           attr_sprite_i,
  input  logic [1:0]              attr_field_i,
  input  logic [7:0]              attr_wdata_i,
  input  logic                    bm_we_i,
  input  logic [IW-1:0]           bm_sprite_i,
  input  logic [RW-1:0]           bm_row_i,
  input  logic [SPRITE_WIDTH-1:0] bm_data_i,
  output logic [5:0]              rrggbb_o,
  output logic [NUM_SPRITES-1:0]  collision_o,
  output logic                    collision_valid_o
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] MAX_X = CW1'(WIDTH_SMALL - SPRITE_WIDTH);
  localparam logic [CW1-1:0] MAX_Y = CW1'(HEIGHT_SMALL - SPRITE_HEIGHT);
  localparam logic [CW1-1:0] SPR_W = CW1'(SPRITE_WIDTH);
  localparam logic [CW1-1:0] SPR_H = CW1'(SPRITE_HEIGHT);
  localparam logic [SPRITE_WIDTH-1:0] MSB_MASK = {1'b1, {(SPRITE_WIDTH-1){1'b0}}};
  localparam logic [5:0] RESET_COLOR = 6'b110001;

  logic [7:0]              pend_x_r     [NUM_SPRITES];
  logic [7:0]              pend_y_r     [NUM_SPRITES];
  logic [5:0]              pend_color_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  pend_en_r;
  logic [CW1-1:0]          act_x_r      [NUM_SPRITES];
  logic [CW1-1:0]          act_y_r      [NUM_SPRITES];
  logic [5:0]              act_color_r  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  act_en_r;
  logic [SPRITE_WIDTH-1:0] bitmap_r     [NUM_SPRITES][SPRITE_HEIGHT];

  logic [NUM_SPRITES-1:0]  acc_r;
  logic [NUM_SPRITES-1:0]  coll_r;
  logic                    coll_valid_r;
  logic [5:0]              rrggbb_r;

  logic                    attr_ok_s;
  logic                    bm_ok_s;
  logic [CW1-1:0]          hx_s;
  logic [CW1-1:0]          vy_s;
  logic [NUM_SPRITES-1:0]  hit_s;
  logic [NUM_SPRITES-1:0]  coll_hit_s;
  logic [5:0]              pix_color_s;

  function automatic logic [CW1-1:0] clamp_coord(input logic [7:0] v, input logic [CW1-1:0] lim);
    logic [CW1-1:0] ext;
    ext = CW1'(v);
    if (ext > lim) begin
      return lim;
    end else begin
      return ext;
    end
  endfunction

  assign attr_ok_s = attr_we_i && ({1'b0, attr_sprite_i} < (IW+1)'(NUM_SPRITES));
  assign bm_ok_s   = bm_we_i && ({1'b0, bm_sprite_i} < (IW+1)'(NUM_SPRITES))
                     && ({1'b0, bm_row_i} < (RW+1)'(SPRITE_HEIGHT));
  assign hx_s = CW1'(counter_h_i >> SCALE_LOG2);
  assign vy_s = CW1'(counter_v_i >> SCALE_LOG2);

  // Pending attribute writes and the frame-boundary pending-to-active swap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_x_r[i]     <= 8'd0;
        pend_y_r[i]     <= 8'd0;
        pend_color_r[i] <= RESET_COLOR;
        act_x_r[i]      <= {CW1{1'b0}};
        act_y_r[i]      <= {CW1{1'b0}};
        act_color_r[i]  <= RESET_COLOR;
      end
      pend_en_r <= {NUM_SPRITES{1'b0}};
      act_en_r  <= {NUM_SPRITES{1'b0}};
    end else begin
      if (attr_ok_s) begin
        case (attr_field_i)
          2'd0:    pend_x_r[attr_sprite_i]     <= attr_wdata_i;
          2'd1:    pend_y_r[attr_sprite_i]     <= attr_wdata_i;
          2'd2:    pend_color_r[attr_sprite_i] <= attr_wdata_i[5:0];
          2'd3:    pend_en_r[attr_sprite_i]    <= attr_wdata_i[0];
          default: pend_en_r <= pend_en_r;
        endcase
      end
      // The swap reads pending before any same-cycle write lands.
      if (next_frame_i) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_x_r[i]     <= clamp_coord(pend_x_r[i], MAX_X);
          act_y_r[i]     <= clamp_coord(pend_y_r[i], MAX_Y);
          act_color_r[i] <= pend_color_r[i];
        end
        act_en_r <= pend_en_r;
      end
    end
  end

  // Sprite bitmap rows, written directly with no shadow copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        for (int r = 0; r < SPRITE_HEIGHT; r++) begin
          bitmap_r[i][r] <= {SPRITE_WIDTH{1'b0}};
        end
      end
    end else if (bm_ok_s) begin
      bitmap_r[bm_sprite_i][bm_row_i] <= bm_data_i;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic [CW1-1:0]          dx_s;
    logic [CW1-1:0]          dy_s;
    logic                    in_win_s;
    logic [SPRITE_WIDTH-1:0] row_bits_s;
    assign dx_s       = hx_s - act_x_r[g];
    assign dy_s       = vy_s - act_y_r[g];
    assign in_win_s   = (hx_s >= act_x_r[g]) && (hx_s < act_x_r[g] + SPR_W)
                        && (vy_s >= act_y_r[g]) && (vy_s < act_y_r[g] + SPR_H);
    assign row_bits_s = bitmap_r[g][dy_s];
    assign hit_s[g]   = act_en_r[g] && in_win_s && (|(row_bits_s & (MSB_MASK >> dx_s)));
  end

  // Priority pick: lowest-index hitting sprite overrides the background.
  always_comb begin
    pix_color_s = bg_color_i;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        pix_color_s = act_color_r[i];
      end else begin
        pix_color_s = pix_color_s;
      end
    end
    if (!blank_i && ($countones(hit_s) > 1)) begin
      coll_hit_s = hit_s;
    end else begin
      coll_hit_s = {NUM_SPRITES{1'b0}};
    end
  end

  // Registered pixel output and collision accumulator / per-frame report.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrggbb_r     <= 6'd0;
      acc_r        <= {NUM_SPRITES{1'b0}};
      coll_r       <= {NUM_SPRITES{1'b0}};
      coll_valid_r <= 1'b0;
    end else begin
      rrggbb_r <= blank_i ? 6'd0 : pix_color_s;
      if (next_frame_i) begin
        coll_r       <= acc_r | coll_hit_s;
        acc_r        <= {NUM_SPRITES{1'b0}};
        coll_valid_r <= 1'b1;
      end else begin
        acc_r        <= acc_r | coll_hit_s;
        coll_valid_r <= 1'b0;
      end
    end
  end

  assign rrggbb_o          = rrggbb_r;
  assign collision_o       = coll_r;
  assign collision_valid_o = coll_valid_r;

endmodule

// File: tb/tb_multi_sprite_compositor.sv
// Directed bench for multi_sprite_compositor: pixel expectations queued at drive
// time and popped when the registered output appears.
module tb_multi_sprite_compositor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [10:0] counter_h_i, counter_v_i;
  logic        blank_i, next_frame_i;
  logic [5:0]  bg_color_i;
  logic        attr_we_i;
  logic [1:0]  attr_sprite_i;
  logic [1:0]  attr_field_i;
  logic [7:0]  attr_wdata_i;
  logic        bm_we_i;
  logic [1:0]  bm_sprite_i;
  logic [3:0]  bm_row_i;
  logic [11:0] bm_data_i;
  logic [5:0]  rrggbb_o;
  logic [3:0]  collision_o;
  logic        collision_valid_o;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  multi_sprite_compositor dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .counter_h_i(counter_h_i), .counter_v_i(counter_v_i),
    .blank_i(blank_i), .next_frame_i(next_frame_i), .bg_color_i(bg_color_i),
    .attr_we_i(attr_we_i), .attr_sprite_i(attr_sprite_i),
    .attr_field_i(attr_field_i), .attr_wdata_i(attr_wdata_i),
    .bm_we_i(bm_we_i), .bm_sprite_i(bm_sprite_i), .bm_row_i(bm_row_i),
    .bm_data_i(bm_data_i),
    .rrggbb_o(rrggbb_o), .collision_o(collision_o),
    .collision_valid_o(collision_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_pix(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(rrggbb_o), 32'(e));
    end
  endtask

  task automatic attr(input int s, input int f, input int d);
    @(negedge clk_i);
    attr_we_i = 1'b1; attr_sprite_i = s[1:0]; attr_field_i = f[1:0]; attr_wdata_i = d[7:0];
    @(posedge clk_i); #1;
    attr_we_i = 1'b0;
  endtask

  task automatic bm(input int s, input int r, input logic [11:0] d);
    @(negedge clk_i);
    bm_we_i = 1'b1; bm_sprite_i = s[1:0]; bm_row_i = r[3:0]; bm_data_i = d;
    @(posedge clk_i); #1;
    bm_we_i = 1'b0;
  endtask

  task automatic px(input string tag, input int h, input int v, input logic blk,
                    input logic [5:0] bg, input logic [5:0] expv);
    @(negedge clk_i);
    counter_h_i = h[10:0]; counter_v_i = v[10:0]; blank_i = blk; bg_color_i = bg;
    exp_q.push_back(expv);
    @(posedge clk_i); #1;
    pop_pix(tag);
    blank_i = 1'b1;
  endtask

  task automatic frame(input string tag, input int h, input int v, input logic blk,
                       input logic [5:0] bg, input logic [5:0] exp_pix, input logic [3:0] exp_coll,
                       input logic aw = 1'b0, input int as = 0, input int af = 0, input int ad = 0);
    @(negedge clk_i);
    counter_h_i = h[10:0]; counter_v_i = v[10:0]; blank_i = blk; bg_color_i = bg;
    next_frame_i = 1'b1;
    attr_we_i = aw; attr_sprite_i = as[1:0]; attr_field_i = af[1:0]; attr_wdata_i = ad[7:0];
    exp_q.push_back(exp_pix);
    @(posedge clk_i); #1;
    next_frame_i = 1'b0; attr_we_i = 1'b0; blank_i = 1'b1;
    pop_pix({tag, "_pix"});
    chk({tag, "_valid"}, 32'(collision_valid_o), 32'd1);
    chk({tag, "_coll"}, 32'(collision_o), 32'(exp_coll));
    @(posedge clk_i); #1;
    chk({tag, "_valid_drop"}, 32'(collision_valid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; counter_h_i = 11'd0; counter_v_i = 11'd0; blank_i = 1'b1;
    next_frame_i = 1'b0; bg_color_i = 6'd0; attr_we_i = 1'b0; attr_sprite_i = 2'd0;
    attr_field_i = 2'd0; attr_wdata_i = 8'd0; bm_we_i = 1'b0; bm_sprite_i = 2'd0;
    bm_row_i = 4'd0; bm_data_i = 12'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_rgb", 32'(rrggbb_o), 32'd0);
    chk("reset_coll", 32'(collision_o), 32'd0);
    chk("reset_valid", 32'(collision_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Sprite 0 at big (10,5), white, fully opaque
    for (int r = 0; r < 12; r++) bm(0, r, 12'hFFF);
    attr(0, 0, 10); attr(0, 1, 5); attr(0, 2, 8'h3F); attr(0, 3, 8'hFF);
    px("pre_swap", 80, 40, 1'b0, 6'h0A, 6'h0A);
    frame("f1", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("s0_tl", 80, 40, 1'b0, 6'h0A, 6'h3F);
    px("s0_left_out", 79, 40, 1'b0, 6'h0A, 6'h0A);
    px("s0_br", 175, 135, 1'b0, 6'h12, 6'h3F);
    px("s0_right_out", 176, 135, 1'b0, 6'h12, 6'h12);
    px("s0_top_out", 80, 39, 1'b0, 6'h07, 6'h07);
    px("s0_bot_out", 175, 136, 1'b0, 6'h07, 6'h07);
    px("s0_blank", 120, 100, 1'b1, 6'h07, 6'h00);

    // Sprite 1: same-cycle write vs swap, then clamping of x=200
    for (int r = 0; r < 12; r++) bm(1, r, 12'hFFF);
    attr(1, 0, 30); attr(1, 1, 20); attr(1, 2, 8'h0C); attr(1, 3, 8'h01);
    frame("f2", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    frame("f3", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000, 1'b1, 1, 0, 200);
    px("s1_old_x", 240, 160, 1'b0, 6'h01, 6'h0C);
    frame("f4", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("s1_moved", 240, 160, 1'b0, 6'h01, 6'h01);
    px("s1_clamp_l", 704, 160, 1'b0, 6'h01, 6'h0C);
    px("s1_clamp_lo", 696, 160, 1'b0, 6'h01, 6'h01);
    px("s1_clamp_br", 799, 255, 1'b0, 6'h01, 6'h0C);
    px("s1_clamp_bo", 799, 256, 1'b0, 6'h01, 6'h01);

    // Sprite 2 overlapping sprite 0: priority and collision report
    for (int r = 0; r < 12; r++) bm(2, r, 12'hFFF);
    attr(2, 0, 15); attr(2, 1, 10); attr(2, 2, 8'h30); attr(2, 3, 8'h01);
    frame("f5", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("ovl_blank", 128, 88, 1'b1, 6'h02, 6'h00);
    frame("f6_blank_nocoll", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("ovl_prio", 128, 88, 1'b0, 6'h02, 6'h3F);
    px("s2_only", 200, 160, 1'b0, 6'h02, 6'h30);
    frame("f7_coll", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0101);
    frame("f8_samecycle", 128, 88, 1'b0, 6'h02, 6'h3F, 4'b0101);
    attr(2, 0, 60);
    frame("f9", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("apart_s0", 128, 88, 1'b0, 6'h02, 6'h3F);
    px("apart_s2", 480, 80, 1'b0, 6'h02, 6'h30);
    frame("f10_apart", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);

    // Sprite 3 at origin with a sparse row 0
    bm(3, 0, 12'b100000000001);
    attr(3, 0, 0); attr(3, 1, 0); attr(3, 2, 8'h15); attr(3, 3, 8'h01);
    frame("f11", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("row0_hx0", 0, 0, 1'b0, 6'h0A, 6'h15);
    px("row0_hx1", 8, 0, 1'b0, 6'h0A, 6'h0A);
    px("row0_hx11", 88, 0, 1'b0, 6'h0A, 6'h15);
    px("row0_hx10", 87, 7, 1'b0, 6'h0A, 6'h0A);
    px("row0_hx11_sub", 95, 7, 1'b0, 6'h0A, 6'h15);
    px("row1_empty", 0, 8, 1'b0, 6'h0A, 6'h0A);
    bm(3, 1, 12'h800);
    px("row1_immediate", 0, 8, 1'b0, 6'h0A, 6'h15);
    bm(3, 12, 12'hFFF);
    px("row_oob_ignored", 8, 8, 1'b0, 6'h0A, 6'h0A);

    // Build a pending collision, then reset mid-frame
    attr(2, 0, 10);
    frame("f12", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("pre_rst_ovl", 128, 88, 1'b0, 6'h02, 6'h3F);
    @(negedge clk_i);
    rst_i = 1'b1; counter_h_i = 11'd80; counter_v_i = 11'd40; blank_i = 1'b0; bg_color_i = 6'h2A;
    @(posedge clk_i); #1;
    chk("midrst_rgb", 32'(rrggbb_o), 32'd0);
    chk("midrst_coll", 32'(collision_o), 32'd0);
    chk("midrst_valid", 32'(collision_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; blank_i = 1'b1;
    px("post_rst_bg", 80, 40, 1'b0, 6'h2A, 6'h2A);
    frame("f13_acc_cleared", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("post_rst_disabled", 80, 40, 1'b0, 6'h2A, 6'h2A);
    bm(0, 0, 12'hFFF);
    attr(0, 3, 8'h01);
    frame("f14", 0, 0, 1'b1, 6'h00, 6'h00, 4'b0000);
    px("rst_color_pos", 0, 0, 1'b0, 6'h2A, 6'b110001);
    px("rst_pos_edge", 96, 0, 1'b0, 6'h2A, 6'h2A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
